// File: rtl/rgb_fade_engine.sv
// rgb_fade_engine: ramps 8-bit RGB PWM setpoints toward an accepted target colour.
// Optional RGB_FADE_GAMMA_EN adds a registered square-law output stage (+1 cycle).

// Per-channel step: moves cur toward tgt by at most STEP_SIZE, never past it.
module rgb_fade_lane #(
  parameter int STEP_SIZE = 1
) (
  input  logic [7:0] cur,
  input  logic [7:0] tgt,
  output logic [7:0] nxt
);
  logic [8:0] diff;

  always_comb begin
    nxt  = cur;
    diff = '0;
    if (cur < tgt) begin
      diff = {1'b0, tgt} - {1'b0, cur};
      nxt  = (diff > 9'(STEP_SIZE)) ? cur + 8'(STEP_SIZE) : tgt;
    end else if (cur > tgt) begin
      diff = {1'b0, cur} - {1'b0, tgt};
      nxt  = (diff > 9'(STEP_SIZE)) ? cur - 8'(STEP_SIZE) : tgt;
    end
  end
endmodule

`ifdef RGB_FADE_GAMMA_EN
// Registered square-law: (lin*lin + lin) >> 8 maps 0->0 and 255->255.
module rgb_gamma_lane (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] lin,
  output logic [7:0] out
);
  logic [15:0] sq;

  assign sq = 16'(lin) * 16'(lin) + 16'(lin);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out <= '0;
    else        out <= 8'(sq >> 8);
  end
endmodule
`endif

module rgb_fade_engine #(
  parameter int STEP_DIV  = 1024,
  parameter int STEP_SIZE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tgt_valid,
  output logic       tgt_ready,
  input  logic [7:0] tgt_red,
  input  logic [7:0] tgt_green,
  input  logic [7:0] tgt_blue,
  input  logic       fade_en,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       busy,
  output logic       done
);
  localparam int NUM_LANES = 3;
  localparam int PW        = $clog2(STEP_DIV) + 1;

  typedef enum logic {IDLE, FADING} state_t;

  typedef struct packed {
    logic [NUM_LANES-1:0][7:0] rgb;
    logic                      fade;
  } tgt_req_t;

  state_t                    state;
  tgt_req_t                  req;
  logic [PW-1:0]             pres;
  logic [NUM_LANES-1:0][7:0] cur, tgt, nxt, lvl;
  logic [NUM_LANES-1:0]      lane_eq;
  logic                      rdy, lin_busy, lin_done, tick;

  // lane 0 = red, 1 = green, 2 = blue
  assign req.rgb  = {tgt_blue, tgt_green, tgt_red};
  assign req.fade = fade_en;
  assign tick     = (state == FADING) && (pres == PW'(STEP_DIV - 1));

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    rgb_fade_lane #(.STEP_SIZE(STEP_SIZE)) u_lane (
      .cur (cur[i]),
      .tgt (tgt[i]),
      .nxt (nxt[i])
    );
    assign lane_eq[i] = (nxt[i] == tgt[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rdy      <= 1'b1;
      pres     <= '0;
      cur      <= '0;
      tgt      <= '0;
      lin_busy <= 1'b0;
      lin_done <= 1'b0;
    end else begin
      lin_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tgt_valid && rdy) begin
            tgt <= req.rgb;
            if (!req.fade) begin
              cur      <= req.rgb;
              lin_done <= 1'b1;
            end else if (req.rgb == cur) begin
              lin_done <= 1'b1;
            end else begin
              state    <= FADING;
              rdy      <= 1'b0;
              lin_busy <= 1'b1;
              pres     <= '0;
            end
          end
        end
        FADING: begin
          pres <= tick ? '0 : pres + 1'b1;
          if (tick) begin
            cur <= nxt;
            // finishing tick: completion flags land with the final level
            if (&lane_eq) begin
              state    <= IDLE;
              rdy      <= 1'b1;
              lin_busy <= 1'b0;
              lin_done <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          rdy   <= 1'b1;
        end
      endcase
    end
  end

  assign tgt_ready = rdy;

`ifdef RGB_FADE_GAMMA_EN
  logic busy_q, done_q;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_gamma
    rgb_gamma_lane u_gamma (
      .clk   (clk),
      .rst_n (rst_n),
      .lin   (cur[i]),
      .out   (lvl[i])
    );
  end

  // status follows the gamma stage so it stays aligned with the outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= lin_busy;
      done_q <= lin_done;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
`else
  assign lvl  = cur;
  assign busy = lin_busy;
  assign done = lin_done;
`endif

  assign red   = lvl[0];
  assign green = lvl[1];
  assign blue  = lvl[2];
endmodule
